// File: rtl/riscv_wb_stage_pkg.sv
// Shared definitions for the RV32I write-back stage: datapath width,
// load funct3 encodings and the write-back FSM state type.
package riscv_wb_stage_pkg;

    localparam int RV_XLEN = 32;

    // Load funct3 encodings (RV32I base ISA)
    localparam logic [2:0] FUNCT3_LB  = 3'b000;
    localparam logic [2:0] FUNCT3_LH  = 3'b001;
    localparam logic [2:0] FUNCT3_LW  = 3'b010;
    localparam logic [2:0] FUNCT3_LBU = 3'b100;
    localparam logic [2:0] FUNCT3_LHU = 3'b101;

    typedef enum logic {
        WB_IDLE      = 1'b0,
        WB_LOAD_WAIT = 1'b1
    } wb_state_e;

endpackage

// File: rtl/riscv_ld_align.sv
// Load data aligner: extracts the addressed byte/half/word from a raw
// memory word and sign- or zero-extends it. Flags unknown funct3 codes.
module riscv_ld_align
    import riscv_wb_stage_pkg::*;
#(
    parameter int XLEN = RV_XLEN
)(
    input  logic [2:0]      funct3,
    input  logic [1:0]      offset,
    input  logic [XLEN-1:0] raw,
    output logic [XLEN-1:0] aligned,
    output logic            bad_f3
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    // Byte lane follows the full offset; half lane only looks at offset[1]
    assign lane_byte = raw[{offset, 3'b000} +: 8];
    assign lane_half = offset[1] ? raw[31:16] : raw[15:0];

    // Extend the selected lane according to the load type
    always_comb begin
        aligned = '0;
        bad_f3  = 1'b0;
        case (funct3)
            FUNCT3_LB:  aligned = {{(XLEN-8){lane_byte[7]}}, lane_byte};
            FUNCT3_LBU: aligned = {{(XLEN-8){1'b0}}, lane_byte};
            FUNCT3_LH:  aligned = {{(XLEN-16){lane_half[15]}}, lane_half};
            FUNCT3_LHU: aligned = {{(XLEN-16){1'b0}}, lane_half};
            FUNCT3_LW:  aligned = raw;
            default:    bad_f3  = 1'b1;
        endcase
    end

endmodule

// File: rtl/riscv_mux.sv
// Generic N-input one-hot-free selector over a flat concatenation.
// Out-of-range selects produce zero.
module riscv_mux #(
    parameter int N_MUX_IN = 4,
    parameter int WIDTH    = 32,
    parameter int SEL_W    = (N_MUX_IN > 1) ? $clog2(N_MUX_IN) : 1
)(
    input  logic [SEL_W-1:0]          sel,
    input  logic [N_MUX_IN*WIDTH-1:0] in_concat,
    output logic [WIDTH-1:0]          out
);

    // Pick the selected slot; anything past the last input reads as zero
    always_comb begin
        // NOTE: assigning a default before the loop means every path drives
        // 'out', so no latch is inferred for unmatched select values.
        out = '0;
        for (int k = 0; k < N_MUX_IN; k++) begin
            if (sel == SEL_W'(k)) begin
                out = in_concat[k*WIDTH +: WIDTH];
            end
        end
    end

endmodule

// File: rtl/riscv_wb_stage.sv
// Registered write-back stage: selects the result source, aligns load data,
// waits (bounded) for late data-memory responses and drives the register-file
// write port, which doubles as the forwarding source.
module riscv_wb_stage
    import riscv_wb_stage_pkg::*;
#(
    parameter int  XLEN     = RV_XLEN,
    parameter int  N_SRC    = 4,
    parameter int  LOAD_SRC = 1,
    parameter int  TIMEOUT  = 255,
    localparam int SRC_W    = (N_SRC > 1) ? $clog2(N_SRC) : 1
)(
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_wb_valid,
    output logic                  o_wb_ready,
    input  logic [SRC_W-1:0]      i_wb_ctrl_rd_src,
    input  logic [N_SRC*XLEN-1:0] i_wb_concat_data,
    input  logic                  i_wb_rd_we,
    input  logic [4:0]            i_wb_rd_addr,
    input  logic [2:0]            i_wb_ld_funct3,
    input  logic [1:0]            i_wb_ld_offset,
    input  logic                  i_wb_dmem_rvalid,
    input  logic [XLEN-1:0]       i_wb_dmem_rdata,
    output logic                  o_wb_rf_we,
    output logic [4:0]            o_wb_rf_addr,
    output logic [XLEN-1:0]       o_wb_rf_data,
    output logic                  o_wb_err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    wb_state_e        state, state_next;
    logic [CNT_W-1:0] cnt;

    // Load context captured when a load has to wait for its data
    logic             cap_we;
    logic [4:0]       cap_addr;
    logic [2:0]       cap_f3;
    logic [1:0]       cap_off;

    logic             accept;
    logic             is_load;
    logic             src_bad;
    logic [2:0]       align_f3;
    logic [1:0]       align_off;
    logic [XLEN-1:0]  aligned;
    logic             bad_f3;
    logic [XLEN-1:0]  mux_out;

    // Write/transition decisions for the current cycle
    logic             do_write;
    logic             do_capture;
    logic             do_abort;
    logic             wr_we;
    logic [4:0]       wr_addr;
    logic [XLEN-1:0]  wr_data;
    logic             wr_err;

    assign o_wb_ready = (state == WB_IDLE);
    assign accept     = i_wb_valid & o_wb_ready;
    assign is_load    = (i_wb_ctrl_rd_src == SRC_W'(LOAD_SRC));
    assign src_bad    = ({1'b0, i_wb_ctrl_rd_src} >= (SRC_W+1)'(N_SRC));

    // A waiting load aligns with its captured type/offset, otherwise the live ones
    assign align_f3  = (state == WB_LOAD_WAIT) ? cap_f3  : i_wb_ld_funct3;
    assign align_off = (state == WB_LOAD_WAIT) ? cap_off : i_wb_ld_offset;

    riscv_ld_align #(
        .XLEN (XLEN)
    ) u_ld_align (
        .funct3  (align_f3),
        .offset  (align_off),
        .raw     (i_wb_dmem_rdata),
        .aligned (aligned),
        .bad_f3  (bad_f3)
    );

    riscv_mux #(
        .N_MUX_IN (N_SRC),
        .WIDTH    (XLEN),
        .SEL_W    (SRC_W)
    ) u_src_mux (
        .sel       (i_wb_ctrl_rd_src),
        .in_concat (i_wb_concat_data),
        .out       (mux_out)
    );

    // Next-state and per-cycle write decision
    always_comb begin
        state_next = state;
        do_write   = 1'b0;
        do_capture = 1'b0;
        do_abort   = 1'b0;
        wr_we      = 1'b0;
        wr_addr    = i_wb_rd_addr;
        wr_data    = mux_out;
        wr_err     = 1'b0;
        case (state)
            WB_IDLE: begin
                if (accept) begin
                    if (is_load && !i_wb_dmem_rvalid) begin
                        do_capture = 1'b1;
                        state_next = WB_LOAD_WAIT;
                    end else begin
                        do_write = 1'b1;
                        wr_we    = i_wb_rd_we;
                        wr_addr  = i_wb_rd_addr;
                        wr_data  = is_load ? aligned : mux_out;
                        wr_err   = src_bad | (is_load & bad_f3);
                    end
                end
            end
            WB_LOAD_WAIT: begin
                // A response on the timeout cycle still wins over the abort
                if (i_wb_dmem_rvalid) begin
                    do_write   = 1'b1;
                    wr_we      = cap_we;
                    wr_addr    = cap_addr;
                    wr_data    = aligned;
                    wr_err     = bad_f3;
                    state_next = WB_IDLE;
                end else if (cnt == CNT_W'(TIMEOUT)) begin
                    do_abort   = 1'b1;
                    state_next = WB_IDLE;
                end
            end
            default: state_next = WB_IDLE;
        endcase
    end

    // State register, wait counter and captured load context
    always_ff @(posedge i_clk or posedge i_rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (i_rst) begin
            state    <= WB_IDLE;
            cnt      <= '0;
            cap_we   <= 1'b0;
            cap_addr <= '0;
            cap_f3   <= '0;
            cap_off  <= '0;
        end else begin
            state <= state_next;
            if (do_capture) begin
                cnt      <= '0;
                cap_we   <= i_wb_rd_we;
                cap_addr <= i_wb_rd_addr;
                cap_f3   <= i_wb_ld_funct3;
                cap_off  <= i_wb_ld_offset;
            end else if (state == WB_LOAD_WAIT && state_next == WB_LOAD_WAIT) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Register-file write port and sticky error flag
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_wb_rf_we   <= 1'b0;
            o_wb_rf_addr <= '0;
            o_wb_rf_data <= '0;
            o_wb_err     <= 1'b0;
        end else begin
            // Writes to x0 are suppressed but address/data still follow
            o_wb_rf_we <= do_write & wr_we & (wr_addr != 5'd0);
            if (do_write) begin
                o_wb_rf_addr <= wr_addr;
                o_wb_rf_data <= wr_data;
            end
            if ((do_write & wr_err) | do_abort) begin
                o_wb_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_riscv_wb_stage.sv
// Self-checking bench for riscv_wb_stage: directed vector table, reset and
// out-of-range corner sequences, then randomized loads/ops against a model.
module tb_riscv_wb_stage;

    localparam int XLEN    = 32;
    localparam int N_SRC   = 4;
    localparam int TIMEOUT = 4;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  valid = 1'b0;
    logic                  valid3 = 1'b0;
    logic [1:0]            src = '0;
    logic [N_SRC*XLEN-1:0] concat = '0;
    logic [3*XLEN-1:0]     concat3;
    logic                  we = 1'b0;
    logic [4:0]            rd = '0;
    logic [2:0]            f3 = '0;
    logic [1:0]            off = '0;
    logic                  rvalid = 1'b0;
    logic [XLEN-1:0]       rdata = '0;

    logic                  ready, rf_we, err;
    logic [4:0]            rf_addr;
    logic [XLEN-1:0]       rf_data;
    logic                  ready3, rf_we3, err3;
    logic [4:0]            rf_addr3;
    logic [XLEN-1:0]       rf_data3;

    assign concat3 = concat[3*XLEN-1:0];

    always #5 clk = ~clk;

    riscv_wb_stage #(
        .XLEN (XLEN), .N_SRC (N_SRC), .LOAD_SRC (1), .TIMEOUT (TIMEOUT)
    ) dut (
        .i_clk (clk), .i_rst (rst), .i_wb_valid (valid), .o_wb_ready (ready),
        .i_wb_ctrl_rd_src (src), .i_wb_concat_data (concat),
        .i_wb_rd_we (we), .i_wb_rd_addr (rd), .i_wb_ld_funct3 (f3),
        .i_wb_ld_offset (off), .i_wb_dmem_rvalid (rvalid), .i_wb_dmem_rdata (rdata),
        .o_wb_rf_we (rf_we), .o_wb_rf_addr (rf_addr), .o_wb_rf_data (rf_data),
        .o_wb_err (err)
    );

    // Non-power-of-two source count, so select value 3 is out of range
    riscv_wb_stage #(
        .XLEN (XLEN), .N_SRC (3), .LOAD_SRC (1), .TIMEOUT (TIMEOUT)
    ) dut3 (
        .i_clk (clk), .i_rst (rst), .i_wb_valid (valid3), .o_wb_ready (ready3),
        .i_wb_ctrl_rd_src (src), .i_wb_concat_data (concat3),
        .i_wb_rd_we (we), .i_wb_rd_addr (rd), .i_wb_ld_funct3 (f3),
        .i_wb_ld_offset (off), .i_wb_dmem_rvalid (rvalid), .i_wb_dmem_rdata (rdata),
        .o_wb_rf_we (rf_we3), .o_wb_rf_addr (rf_addr3), .o_wb_rf_data (rf_data3),
        .o_wb_err (err3)
    );

    typedef struct {
        logic [1:0]  src;
        logic [31:0] data;
        logic [4:0]  rd;
        logic        we;
        logic [2:0]  f3;
        logic [1:0]  off;
        logic [31:0] rdata;
        int          delay;    // cycles from accept to rvalid (0 = same cycle)
        logic        exp_we;
        logic [31:0] exp_data;
        logic        exp_err;  // sticky error value expected after the op
    } vec_t;

    int tests = 0;
    int fails = 0;

    // Expected last-written address/data (held across aborted loads)
    logic [4:0]  m_addr = '0;
    logic [31:0] m_data = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference load semantics from the ISA definition, using plain arithmetic
    function automatic logic [31:0] ref_load(input logic [2:0] t, input int o,
                                             input logic [31:0] raw, output bit bad);
        int unsigned w, b, h;
        w   = raw;
        b   = (w >> (8 * o)) % 256;
        h   = (w >> (16 * (o / 2))) % 65536;
        bad = 1'b0;
        case (t)
            3'b000:  return (b >= 128) ? b + 32'hFFFF_FF00 : b;
            3'b100:  return b;
            3'b001:  return (h >= 32768) ? h + 32'hFFFF_0000 : h;
            3'b101:  return h;
            3'b010:  return w;
            default: begin bad = 1'b1; return 32'h0; end
        endcase
    endfunction

    // Fill every source slot with noise, then place the wanted value
    task automatic fill_concat(input logic [1:0] s, input logic [31:0] d);
        for (int k = 0; k < N_SRC; k++) concat[k*XLEN +: XLEN] = $urandom;
        concat[s*XLEN +: XLEN] = d;
    endtask

    // Drive one instruction, serve its load response after v.delay cycles, check the result
    task automatic apply(input string name, input vec_t v);
        bit load_op, done, wrote;
        load_op = (v.src == 2'd1);
        wrote   = !(load_op && v.delay > TIMEOUT + 1);
        @(negedge clk);
        valid = 1'b1; src = v.src; rd = v.rd; we = v.we; f3 = v.f3; off = v.off;
        rdata = v.rdata;
        fill_concat(v.src, v.data);
        rvalid = load_op && (v.delay == 0);
        @(posedge clk); #1;
        valid  = 1'b0;
        rvalid = 1'b0;
        done   = !load_op || (v.delay == 0);
        for (int c = 1; c <= TIMEOUT + 1 && !done; c++) begin
            check({name, " wait ready"}, 32'(ready), 32'd0);
            check({name, " wait rf_we"}, 32'(rf_we), 32'd0);
            rvalid = (c == v.delay);
            @(posedge clk); #1;
            rvalid = 1'b0;
            if (c == v.delay) done = 1'b1;
        end
        if (wrote) begin
            m_addr = v.rd;
            m_data = v.exp_data;
        end
        check({name, " rf_we"},   32'(rf_we),   32'(v.exp_we));
        check({name, " rf_addr"}, 32'(rf_addr), 32'(m_addr));
        check({name, " rf_data"}, rf_data,      m_data);
        check({name, " err"},     32'(err),     32'(v.exp_err));
        check({name, " ready"},   32'(ready),   32'd1);
        @(posedge clk); #1;
        check({name, " pulse end"}, 32'(rf_we), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; valid = 1'b0; valid3 = 1'b0; rvalid = 1'b0;
        #1;
        check("reset rf_we",   32'(rf_we),   32'd0);
        check("reset rf_addr", 32'(rf_addr), 32'd0);
        check("reset rf_data", rf_data,      32'd0);
        check("reset err",     32'(err),     32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("post-reset ready", 32'(ready), 32'd1);
        m_addr = '0;
        m_data = '0;
    endtask

    vec_t vecs[14];
    vec_t v;
    logic [2:0] legal_f3[5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

    initial begin
        // src, data, rd, we, f3, off, rdata, delay, exp_we, exp_data, exp_err
        vecs[0]  = '{2'd0, 32'h0000_1234, 5'd5,  1'b1, 3'b000, 2'd0, 32'h0,         0, 1'b1, 32'h0000_1234, 1'b0};
        vecs[1]  = '{2'd1, 32'h0,         5'd6,  1'b1, 3'b000, 2'd3, 32'h80FF_7F01, 0, 1'b1, 32'hFFFF_FF80, 1'b0};
        vecs[2]  = '{2'd1, 32'h0,         5'd7,  1'b1, 3'b100, 2'd0, 32'h80FF_7F01, 0, 1'b1, 32'h0000_0001, 1'b0};
        vecs[3]  = '{2'd1, 32'h0,         5'd8,  1'b1, 3'b001, 2'd2, 32'h80FF_7F01, 0, 1'b1, 32'hFFFF_80FF, 1'b0};
        vecs[4]  = '{2'd1, 32'h0,         5'd9,  1'b1, 3'b101, 2'd0, 32'h80FF_7F01, 0, 1'b1, 32'h0000_7F01, 1'b0};
        vecs[5]  = '{2'd1, 32'h0,         5'd10, 1'b1, 3'b010, 2'd2, 32'hDEAD_BEEF, 3, 1'b1, 32'hDEAD_BEEF, 1'b0};
        vecs[6]  = '{2'd0, 32'h0000_0055, 5'd0,  1'b1, 3'b000, 2'd0, 32'h0,         0, 1'b0, 32'h0000_0055, 1'b0};
        vecs[7]  = '{2'd2, 32'h0000_0104, 5'd1,  1'b1, 3'b000, 2'd0, 32'h0,         0, 1'b1, 32'h0000_0104, 1'b0};
        vecs[8]  = '{2'd3, 32'h0000_C0DE, 5'd31, 1'b1, 3'b000, 2'd0, 32'h0,         0, 1'b1, 32'h0000_C0DE, 1'b0};
        vecs[9]  = '{2'd1, 32'h0,         5'd12, 1'b1, 3'b010, 2'd0, 32'h1357_9BDF, 5, 1'b1, 32'h1357_9BDF, 1'b0};
        vecs[10] = '{2'd1, 32'h0,         5'd2,  1'b1, 3'b001, 2'd3, 32'h80FF_7F01, 1, 1'b1, 32'hFFFF_80FF, 1'b0};
        vecs[11] = '{2'd1, 32'h0,         5'd3,  1'b0, 3'b100, 2'd2, 32'h80FF_7F01, 2, 1'b0, 32'h0000_00FF, 1'b0};
        vecs[12] = '{2'd1, 32'h0,         5'd13, 1'b1, 3'b010, 2'd0, 32'h2468_ACE0, 7, 1'b0, 32'h0,         1'b1};
        vecs[13] = '{2'd0, 32'h0000_CAFE, 5'd14, 1'b1, 3'b000, 2'd0, 32'h0,         0, 1'b1, 32'h0000_CAFE, 1'b1};

        do_reset();
        for (int i = 0; i < 14; i++) apply($sformatf("vec%0d", i), vecs[i]);

        // Unknown load funct3: zero data, write still issued, error raised
        do_reset();
        apply("bad_f3", '{2'd1, 32'h0, 5'd7, 1'b1, 3'b011, 2'd1, 32'hFFFF_FFFF, 0,
                          1'b1, 32'h0, 1'b1});

        // Out-of-range source select on the 3-source instance
        do_reset();
        @(negedge clk);
        valid3 = 1'b1; src = 2'd2; rd = 5'd11; we = 1'b1;
        fill_concat(2'd2, 32'h0000_0077);
        @(posedge clk); #1;
        valid3 = 1'b0;
        check("src3 ok data", rf_data3, 32'h0000_0077);
        check("src3 ok err",  32'(err3), 32'd0);
        @(negedge clk);
        valid3 = 1'b1; src = 2'd3; rd = 5'd4; we = 1'b1;
        fill_concat(2'd3, 32'h5555_AAAA);
        @(posedge clk); #1;
        valid3 = 1'b0;
        check("src oob rf_we",   32'(rf_we3),   32'd1);
        check("src oob rf_addr", 32'(rf_addr3), 32'd4);
        check("src oob rf_data", rf_data3,      32'd0);
        check("src oob err",     32'(err3),     32'd1);

        // Reset during LOAD_WAIT: outputs clear at once, late response ignored
        do_reset();
        apply("pre-rst alu", '{2'd0, 32'h0000_ABCD, 5'd9, 1'b1, 3'b000, 2'd0, 32'h0, 0,
                               1'b1, 32'h0000_ABCD, 1'b0});
        @(negedge clk);
        valid = 1'b1; src = 2'd1; rd = 5'd20; we = 1'b1; f3 = 3'b010; rvalid = 1'b0;
        @(posedge clk); #1;
        valid = 1'b0;
        @(posedge clk); #1;
        check("mid-wait ready", 32'(ready), 32'd0);
        #2 rst = 1'b1;
        #1;
        check("async rst rf_we",   32'(rf_we),   32'd0);
        check("async rst rf_addr", 32'(rf_addr), 32'd0);
        check("async rst rf_data", rf_data,      32'd0);
        @(negedge clk);
        rst = 1'b0; rvalid = 1'b1; rdata = 32'h1111_2222;
        @(posedge clk); #1;
        rvalid = 1'b0;
        check("late rvalid rf_we",   32'(rf_we),   32'd0);
        check("late rvalid rf_data", rf_data,      32'd0);
        check("late rvalid err",     32'(err),     32'd0);
        check("late rvalid ready",   32'(ready),   32'd1);

        // Randomized traffic against the reference model
        do_reset();
        begin
            logic m_err;
            bit bad;
            int r;
            m_err = 1'b0;
            for (int n = 0; n < 150; n++) begin
                v.src   = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 1) == 1) v.src = 2'd1;
                v.data  = $urandom;
                v.rd    = 5'($urandom);
                v.we    = 1'($urandom);
                r       = $urandom_range(0, 39);
                v.f3    = (r == 0) ? 3'b011 : (r == 1) ? 3'b111 : legal_f3[r % 5];
                v.off   = 2'($urandom);
                v.rdata = $urandom;
                v.delay = ($urandom_range(0, 9) < 7) ? $urandom_range(0, 3)
                                                     : $urandom_range(4, 7);
                v.exp_we   = v.we && (v.rd != 5'd0);
                v.exp_data = v.data;
                if (v.src == 2'd1) begin
                    if (v.delay > TIMEOUT + 1) begin
                        v.exp_we = 1'b0;
                        m_err    = 1'b1;
                    end else begin
                        v.exp_data = ref_load(v.f3, int'(v.off), v.rdata, bad);
                        if (bad) m_err = 1'b1;
                    end
                end
                v.exp_err = m_err;
                apply($sformatf("rnd%0d", n), v);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Backstop so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
